ring_output_port: RTL

Parametrised output port for the polarity-interleaved ring router: N-way round-robin arbitration across input-buffer requests, feeding two virtual-channel FIFOs (VC0/VC1) of configurable depth and data width. It generalises the single-entry, two-input even/odd output buffer. Any number of input channels, deeper per-VC buffering, a true round-robin pointer per VC, and occupancy status for flow-control monitoring. One instance sits on each router output (cw, ccw, pe).

---
 rtl/ring_output_port.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ring_output_port.sv
// Output port of the polarity-interleaved ring router: round-robin arbitration over
// NUM_IN input buffers into two VC FIFOs, one filled and the other drained each cycle.
module ring_output_port #(
   parameter int DATA_W = 64,
   parameter int NUM_IN = 2,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     polarity,
   input  logic [NUM_IN-1:0]        req,
   input  logic [NUM_IN*DATA_W-1:0] dataIn,
   output logic [NUM_IN-1:0]        grant,
   output logic                     sendOut,
   input  logic                     readyOut,
   output logic [DATA_W-1:0]        dataOut,
   output logic [CNT_W-1:0]         count0,
   output logic [CNT_W-1:0]         count1
);

   localparam int PTR_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
   localparam int RR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
   localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_IN-1);

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [RR_W-1:0] f_rr_inc(input logic [RR_W-1:0] p);
      return (p == RR_LAST) ? '0 : p + RR_W'(1);
   endfunction

   function automatic logic [RR_W-1:0] f_rr_add(input logic [RR_W-1:0] base, input int ofs);
      int s;
      s = int'(base) + ofs;
      if (s >= NUM_IN) s = s - NUM_IN;
      return RR_W'(s);
   endfunction

   logic [DATA_W-1:0] r_mem0 [DEPTH];
   logic [DATA_W-1:0] r_mem1 [DEPTH];
   logic [PTR_W-1:0]  r_head0, r_tail0, r_head1, r_tail1;
   logic [CNT_W-1:0]  r_cnt0, r_cnt1;
   logic [RR_W-1:0]   r_rr0, r_rr1;

   logic [CNT_W-1:0]  w_fill_cnt, w_drain_cnt;
   logic [RR_W-1:0]   w_rr, w_idx, w_gnt_idx;
   logic              w_full, w_found, w_push, w_pop, w_has;
   logic [DATA_W-1:0] w_din, w_head;

   // Fill side: VC selected by polarity; full is judged on the registered count only
   assign w_fill_cnt = polarity ? r_cnt1 : r_cnt0;
   assign w_full     = (w_fill_cnt == FULL_CNT);
   assign w_rr       = polarity ? r_rr1 : r_rr0;

   always_comb begin
      grant     = '0;
      w_gnt_idx = '0;
      w_idx     = '0;
      w_found   = 1'b0;
      if (reset && !w_full) begin
         for (int k = 0; k < NUM_IN; k++) begin
            w_idx = f_rr_add(w_rr, k);
            if (!w_found && req[w_idx]) begin
               w_found      = 1'b1;
               w_gnt_idx    = w_idx;
               grant[w_idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_din = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) w_din = dataIn[i*DATA_W +: DATA_W];
      end
   end

   assign w_push = w_found;

   // Drain side: the opposite VC; output is masked to zero whenever it is empty
   assign w_drain_cnt = polarity ? r_cnt0 : r_cnt1;
   assign w_has       = (w_drain_cnt != '0);
   assign w_head      = polarity ? r_mem0[r_head0] : r_mem1[r_head1];
   assign sendOut     = w_has & readyOut & reset;
   assign dataOut     = w_has ? w_head : '0;
   assign w_pop       = sendOut;

   assign count0 = r_cnt0;
   assign count1 = r_cnt1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head0 <= '0;
         r_tail0 <= '0;
         r_head1 <= '0;
         r_tail1 <= '0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
         r_rr0   <= '0;
         r_rr1   <= '0;
      end else begin
         if (w_push) begin
            if (polarity) begin
               r_tail1 <= f_ptr_inc(r_tail1);
               r_cnt1  <= r_cnt1 + CNT_W'(1);
               r_rr1   <= f_rr_inc(w_gnt_idx);
            end else begin
               r_tail0 <= f_ptr_inc(r_tail0);
               r_cnt0  <= r_cnt0 + CNT_W'(1);
               r_rr0   <= f_rr_inc(w_gnt_idx);
            end
         end
         if (w_pop) begin
            if (polarity) begin
               r_head0 <= f_ptr_inc(r_head0);
               r_cnt0  <= r_cnt0 - CNT_W'(1);
            end else begin
               r_head1 <= f_ptr_inc(r_head1);
               r_cnt1  <= r_cnt1 - CNT_W'(1);
            end
         end
      end
   end

   // Storage is never reset; stale entries are hidden by the occupancy counts
   always_ff @(posedge clk) begin
      if (w_push) begin
         if (polarity) r_mem1[r_tail1] <= w_din;
         else          r_mem0[r_tail0] <= w_din;
      end
   end

endmodule
